// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c,d} through all 16 vectors, samples f, and checks it against GOLDEN.
// Optional TT_STOP_ON_ERR_EN: end the sweep at the first mismatching sample.
module truth_table_sweeper #(
   parameter int unsigned SETTLE = 1,
   parameter logic [15:0] GOLDEN = 16'h0DD0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        f,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] tt,
   output logic [4:0]  err_count
);

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_vec;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [15:0] r_tt;
   logic [4:0]  r_err;
   logic        w_mis;
   logic        w_last;
   logic [4:0]  w_err_nxt;

   assign w_mis     = f ^ GOLDEN[r_vec];
   assign w_err_nxt = r_err + 5'(w_mis);

`ifdef TT_STOP_ON_ERR_EN
   assign w_last = (r_vec == 4'hF) | w_mis;
`else
   assign w_last = (r_vec == 4'hF);
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (start) w_next = S_SETTLE;
         S_SETTLE: if (r_cnt == 4'd0) w_next = S_SAMPLE;
         S_SAMPLE: w_next = w_last ? S_IDLE : S_SETTLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Datapath follows the state register; start is only seen in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_tt   <= '0;
         r_err  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_vec  <= '0;
                  r_cnt  <= CNT_LOAD;
                  r_tt   <= '0;
                  r_err  <= '0;
                  r_pass <= 1'b0;
                  r_busy <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            end
            S_SAMPLE: begin
               r_tt[r_vec] <= f;
               r_err       <= w_err_nxt;
               if (w_last) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
                  r_vec  <= '0;
                  r_pass <= (w_err_nxt == 5'd0);
               end else begin
                  r_vec <= r_vec + 4'd1;
                  r_cnt <= CNT_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   assign {a, b, c, d} = r_vec;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pass         = r_pass;
   assign tt           = r_tt;
   assign err_count    = r_err;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one SETTLE=1 instance with a
// selectable f source, one SETTLE=3 instance fed by a 2-register delayed model.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       st  = 1'b0;
   logic       sel = 1'b0;
   logic [1:0] mode = 2'd0;

   int total = 0;
   int bad   = 0;

   logic a0, b0, c0, d0, f0, busy0, done0, pass0;
   logic a1, b1, c1, d1, f1, busy1, done1, pass1;
   logic [15:0] tt0, tt1;
   logic [4:0]  ec0, ec1;
   logic st0, st1;
   logic r_d1, r_d2;

   function automatic logic fm(input logic ia, ib, ic, id);
      return (ia ^ ib) & (ic | ~id);
   endfunction

   always_comb begin
      f0 = fm(a0, b0, c0, d0);
      case (mode)
         2'd1: f0 = 1'b0;
         2'd2: f0 = 1'b1;
         2'd3: f0 = ~fm(a0, b0, c0, d0);
         default: ;
      endcase
   end

   always @(posedge clk) begin
      r_d1 <= fm(a1, b1, c1, d1);
      r_d2 <= r_d1;
   end
   assign f1 = r_d2;

   assign st0 = st & ~sel;
   assign st1 = st & sel;

   truth_table_sweeper #(.SETTLE(1)) u0 (
      .clk(clk), .rst(rst), .start(st0),
      .a(a0), .b(b0), .c(c0), .d(d0), .f(f0),
      .busy(busy0), .done(done0), .pass(pass0),
      .tt(tt0), .err_count(ec0)
   );

   truth_table_sweeper #(.SETTLE(3)) u1 (
      .clk(clk), .rst(rst), .start(st1),
      .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
      .busy(busy1), .done(done1), .pass(pass1),
      .tt(tt1), .err_count(ec1)
   );

   wire        w_busy = sel ? busy1 : busy0;
   wire        w_done = sel ? done1 : done0;
   wire        w_pass = sel ? pass1 : pass0;
   wire [15:0] w_tt   = sel ? tt1 : tt0;
   wire [4:0]  w_ec   = sel ? ec1 : ec0;
   wire [3:0]  w_vec  = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int lim, input int i1, input int i2,
                            output int n);
      n = 0;
      while (!w_done && n < lim) begin
         @(posedge clk); #1;
         n++;
         st = (n == i1 || n == i2);
      end
      st = 1'b0;
   endtask

   task automatic sweep(input int lim, input int i1, input int i2,
                        output int n);
      @(negedge clk); st = 1'b1;
      @(posedge clk); #1; st = 1'b0;
      chk("busy_e0", 32'(w_busy), 32'd1);
      chk("vec_e0", 32'(w_vec), 32'd0);
      wait_done(lim, i1, i2, n);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_vec"}, 32'(w_vec), 32'd0);
      chk({tag, "_busy"}, 32'(w_busy), 32'd0);
      chk({tag, "_done"}, 32'(w_done), 32'd0);
      chk({tag, "_pass"}, 32'(w_pass), 32'd0);
      chk({tag, "_tt"}, 32'(w_tt), 32'd0);
      chk({tag, "_ec"}, 32'(w_ec), 32'd0);
   endtask

   initial begin
      int n;
      int dones;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;

      // Correct model, then a start in the done cycle is taken at once
      mode = 2'd0;
      sweep(40, -1, -1, n);
      chk("t1_lat", 32'(n), 32'd32);
      chk("t1_tt", 32'(w_tt), 32'h0DD0);
      chk("t1_ec", 32'(w_ec), 32'd0);
      chk("t1_pass", 32'(w_pass), 32'd1);
      chk("t1_busy", 32'(w_busy), 32'd0);
      chk("t1_vec", 32'(w_vec), 32'd0);
      st = 1'b1;
      @(posedge clk); #1; st = 1'b0;
      chk("t1_done_w", 32'(w_done), 32'd0);
      chk("t1_restart", 32'(w_busy), 32'd1);
      chk("t1_pass_clr", 32'(w_pass), 32'd0);
      wait_done(40, -1, -1, n);
      chk("t1b_lat", 32'(n), 32'd32);
      chk("t1b_tt", 32'(w_tt), 32'h0DD0);

      // f tied low
      mode = 2'd1;
      sweep(40, -1, -1, n);
`ifdef TT_STOP_ON_ERR_EN
      chk("t2_lat", 32'(n), 32'd10);
      chk("t2_ec", 32'(w_ec), 32'd1);
`else
      chk("t2_lat", 32'(n), 32'd32);
      chk("t2_ec", 32'(w_ec), 32'd6);
`endif
      chk("t2_tt", 32'(w_tt), 32'h0000);
      chk("t2_pass", 32'(w_pass), 32'd0);

      // f tied high
      mode = 2'd2;
      sweep(40, -1, -1, n);
`ifdef TT_STOP_ON_ERR_EN
      chk("t3_lat", 32'(n), 32'd2);
      chk("t3_tt", 32'(w_tt), 32'h0001);
      chk("t3_ec", 32'(w_ec), 32'd1);
`else
      chk("t3_lat", 32'(n), 32'd32);
      chk("t3_tt", 32'(w_tt), 32'hFFFF);
      chk("t3_ec", 32'(w_ec), 32'd10);
`endif
      chk("t3_pass", 32'(w_pass), 32'd0);

      // Extra starts while vec = 3 and vec = 9 are ignored
      mode = 2'd0;
      sweep(40, 6, 18, n);
      chk("t4_lat", 32'(n), 32'd32);
      chk("t4_pass", 32'(w_pass), 32'd1);
      @(posedge clk); #1;
      chk("t4_single", 32'(w_done), 32'd0);
      chk("t4_idle", 32'(w_busy), 32'd0);

      // Reset while vec = 7 aborts without a done pulse
      sweep(15, -1, -1, n);
      chk("t4r_vec7", 32'(w_vec), 32'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset("t4r");
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (w_done) dones++;
      end
      chk("t4r_nodone", 32'(dones), 32'd0);

      // Inverted model
      mode = 2'd3;
      sweep(40, -1, -1, n);
`ifdef TT_STOP_ON_ERR_EN
      chk("t5_lat", 32'(n), 32'd2);
      chk("t5_tt", 32'(w_tt), 32'h0001);
      chk("t5_ec", 32'(w_ec), 32'd1);
`else
      chk("t5_lat", 32'(n), 32'd32);
      chk("t5_tt", 32'(w_tt), 32'hF22F);
      chk("t5_ec", 32'(w_ec), 32'd16);
`endif
      chk("t5_pass", 32'(w_pass), 32'd0);
      chk("t5_vec", 32'(w_vec), 32'd0);
      chk("t5_busy", 32'(w_busy), 32'd0);

      // SETTLE = 3 with a two-register function block
      mode = 2'd0;
      sel  = 1'b1;
      sweep(80, -1, -1, n);
      chk("t6_lat", 32'(n), 32'd64);
      chk("t6_tt", 32'(w_tt), 32'h0DD0);
      chk("t6_ec", 32'(w_ec), 32'd0);
      chk("t6_pass", 32'(w_pass), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
